bias_act_pipe: RTL and testbench

Multi-lane bias-add and activation pipeline for the Q1.15 datapath, and the successor to the single-lane bias/activation unit. The block sits between the FMA accumulators and the writeback path. It keeps a per-output-channel bias table instead of a single bias register, adds a programmable clip ceiling and leak shift, and moves LANES results per beat through a 2-stage valid/ready pipeline. Per-beat function select allows mixed-layer streaming without draining.

---
 rtl/bias_act_pipe.sv | 145 ++++++++++++++
 tb/tb_bias_act_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_act_pipe.sv
// Multi-lane bias-add + saturation + activation, two-stage valid/ready pipeline.
// Define ACT_SAT_COUNT_EN to add the sat_count saturation-event counter port.
`timescale 1ns/1ps
module bias_act_pipe #(
    parameter int DATA_BITS   = 16,
    parameter int LANES       = 4,
    parameter int BIAS_DEPTH  = 16,
    parameter int LEAKY_SHIFT = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_BITS-1:0]    in_data,
    input  logic [$clog2(BIAS_DEPTH)-1:0] in_bias_idx,
    input  logic [1:0]                    in_func,
    input  logic                          bias_we,
    input  logic [$clog2(BIAS_DEPTH)-1:0] bias_waddr,
    input  logic [LANES*DATA_BITS-1:0]    bias_wdata,
    input  logic                          clip_we,
    input  logic [DATA_BITS-2:0]          clip_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_BITS-1:0]    out_data
`ifdef ACT_SAT_COUNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int W = LANES * DATA_BITS;
    localparam logic [DATA_BITS-1:0] MAX_VAL = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic [DATA_BITS-1:0] MIN_VAL = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic [W-1:0]           bias_mem [BIAS_DEPTH];
    logic [W-1:0]           bias_row;
    logic                   s1_valid;
    logic                   s2_valid;
    logic [W-1:0]           s1_data;
    logic [1:0]             s1_func;
    logic [DATA_BITS-2:0]   clip;
    logic                   s2_adv;
    logic                   accept;
    logic [W-1:0]           sum_sat;
    logic [W-1:0]           act_data;
    logic [DATA_BITS:0]     lane_sum;
    logic signed [DATA_BITS-1:0] x;
    logic signed [DATA_BITS-1:0] y;
`ifdef ACT_SAT_COUNT_EN
    logic [LANES-1:0]       lane_sat;
    logic [16:0]            sat_next;
`endif

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign bias_row  = bias_mem[in_bias_idx];

    // One extra bit of headroom; overflow shows as the top two bits disagreeing.
    always_comb begin
        sum_sat  = '0;
        lane_sum = '0;
`ifdef ACT_SAT_COUNT_EN
        lane_sat = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_sum = {in_data[i*DATA_BITS+DATA_BITS-1], in_data[i*DATA_BITS +: DATA_BITS]}
                     + {bias_row[i*DATA_BITS+DATA_BITS-1], bias_row[i*DATA_BITS +: DATA_BITS]};
            if (lane_sum[DATA_BITS] != lane_sum[DATA_BITS-1]) begin
                sum_sat[i*DATA_BITS +: DATA_BITS] = lane_sum[DATA_BITS] ? MIN_VAL : MAX_VAL;
`ifdef ACT_SAT_COUNT_EN
                lane_sat[i] = 1'b1;
`endif
            end else begin
                sum_sat[i*DATA_BITS +: DATA_BITS] = lane_sum[DATA_BITS-1:0];
            end
        end
    end

    always_comb begin
        act_data = '0;
        x        = '0;
        y        = '0;
        for (int i = 0; i < LANES; i++) begin
            x = s1_data[i*DATA_BITS +: DATA_BITS];
            y = x;
            case (s1_func)
                2'b01: y = x[DATA_BITS-1] ? '0 : x;
                2'b10: y = x[DATA_BITS-1] ? (x >>> LEAKY_SHIFT) : x;
                2'b11: begin
                    if (x[DATA_BITS-1])
                        y = '0;
                    else if (x[DATA_BITS-2:0] > clip)
                        y = {1'b0, clip};
                end
                default: y = x;
            endcase
            act_data[i*DATA_BITS +: DATA_BITS] = y;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '0;
            s1_func  <= '0;
            out_data <= '0;
            clip     <= '1;
            for (int r = 0; r < BIAS_DEPTH; r++)
                bias_mem[r] <= '0;
        end else begin
            if (bias_we)
                bias_mem[bias_waddr] <= bias_wdata;
            if (clip_we)
                clip <= clip_wdata;
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= sum_sat;
                    s1_func <= in_func;
                end
            end
            // Clip is sampled here, as the beat moves into the output stage.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    out_data <= act_data;
            end
        end
    end

`ifdef ACT_SAT_COUNT_EN
    assign sat_next = {1'b0, sat_count} + 17'($countones(lane_sat));

    always_ff @(posedge clk) begin
        if (!reset_n)
            sat_count <= '0;
        else if (accept)
            sat_count <= sat_next[16] ? 16'hFFFF : sat_next[15:0];
    end
`endif

endmodule

// File: tb/tb_bias_act_pipe.sv
// Self-checking bench for bias_act_pipe: directed vector table, hand-written corner
// sequences, and a randomized stream checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bias_act_pipe;

    localparam int DB = 16;
    localparam int LN = 4;
    localparam int W  = DB * LN;
    localparam int LS = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [3:0]    in_bias_idx = '0;
    logic [1:0]    in_func = '0;
    logic          bias_we = 1'b0;
    logic [3:0]    bias_waddr = '0;
    logic [W-1:0]  bias_wdata = '0;
    logic          clip_we = 1'b0;
    logic [DB-2:0] clip_wdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef ACT_SAT_COUNT_EN
    logic [15:0]   sat_count;
    int            sat_exp = 0;
`endif

    bias_act_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bias_idx(in_bias_idx), .in_func(in_func),
        .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
        .clip_we(clip_we), .clip_wdata(clip_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACT_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: bias table as signed ints, clip ceiling, saturation total.
    int            mb [16][LN];
    int            m_clip = 32767;
    int            m_sat = 0;
    logic [W-1:0]  exp_q [$];
    logic          stall_prev = 1'b0;
    logic [W-1:0]  stall_data = '0;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   idx;
        logic [1:0]   func;
        logic [W-1:0] expv;
        int           nsat;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                           input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] model_beat(input logic [W-1:0] d, input int row,
                                                input int f, output int nsat);
        logic [W-1:0] r;
        int s;
        r = '0;
        nsat = 0;
        for (int i = 0; i < LN; i++) begin
            s = int'($signed(d[i*DB +: DB])) + mb[row][i];
            if (s > 32767) begin s = 32767; nsat++; end
            else if (s < -32768) begin s = -32768; nsat++; end
            case (f)
                1: if (s < 0) s = 0;
                2: if (s < 0) s = (s - (2**LS - 1)) / (2**LS);
                3: begin
                    if (s < 0) s = 0;
                    else if (s > m_clip) s = m_clip;
                end
                default: ;
            endcase
            r[i*DB +: DB] = 16'(s);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        int ns;
        if (!reset_n) begin
            exp_q.delete();
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < LN; i++)
                    mb[r][i] = 0;
            m_clip = 32767;
            m_sat = 0;
            stall_prev = 1'b0;
        end else begin
            // Two slots: input may stall only with both occupied and output blocked.
            check("in_ready", W'(in_ready), W'((exp_q.size() < 2) || out_ready));
            if (stall_prev) begin
                check("stall_valid", W'(out_valid), W'(1));
                check("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", out_data);
                end else begin
                    check("stream_out", out_data, exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_data, int'(in_bias_idx), int'(in_func), ns));
                m_sat = (m_sat + ns > 65535) ? 65535 : m_sat + ns;
            end
            if (bias_we)
                for (int i = 0; i < LN; i++)
                    mb[bias_waddr][i] = int'($signed(bias_wdata[i*DB +: DB]));
            if (clip_we)
                m_clip = int'(clip_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bias(input logic [3:0] row, input logic [W-1:0] d);
        bias_we = 1'b1; bias_waddr = row; bias_wdata = d;
        tick();
        bias_we = 1'b0;
    endtask

    task automatic write_clip(input logic [DB-2:0] c);
        clip_we = 1'b1; clip_wdata = c;
        tick();
        clip_we = 1'b0;
    endtask

    task automatic send_and_check(input vec_t v, input int k);
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = v.data; in_bias_idx = v.idx; in_func = v.func;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 6) begin
            tick();
            n++;
        end
        check($sformatf("vec%0d_latency", k), W'(n), W'(1));
        check($sformatf("vec%0d_data", k), out_data, v.expv);
`ifdef ACT_SAT_COUNT_EN
        sat_exp += v.nsat;
        check($sformatf("vec%0d_sat", k), W'(sat_count), W'(sat_exp));
`endif
    endtask

    function automatic logic [15:0] rnd_lane();
        case ($urandom % 4)
            0: return 16'h7FFF;
            1: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c, acc;

        vecs[0] = '{pack4(16'h2000, 16'h0800, 16'h8000, 16'h0001), 4'd3, 2'b01,
                    pack4(16'h3000, 16'h0000, 16'h0000, 16'h7FFF), 1};
        vecs[1] = '{pack4(16'hFF00, 16'hFFFF, 16'h1234, 16'h8000), 4'd0, 2'b10,
                    pack4(16'hFFFE, 16'hFFFF, 16'h1234, 16'hFF00), 0};
        vecs[2] = '{pack4(16'h6000, 16'h3000, 16'h4000, 16'hC000), 4'd0, 2'b11,
                    pack4(16'h4000, 16'h3000, 16'h4000, 16'h0000), 0};
        vecs[3] = '{pack4(16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF), 4'd6, 2'b00,
                    pack4(16'h8000, 16'h8001, 16'hFFFF, 16'h8000), 2};
        vecs[4] = '{pack4(16'h7FFF, 16'h0000, 16'hFFFF, 16'h0100), 4'd0, 2'b01,
                    pack4(16'h7FFF, 16'h0000, 16'h0000, 16'h0100), 0};
        vecs[5] = '{pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 4'd3, 2'b00,
                    pack4(16'h1000, 16'hF000, 16'h0000, 16'h7FFF), 0};

        tick(); tick();
        reset_n = 1'b1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", W'(in_ready), W'(1));
`ifdef ACT_SAT_COUNT_EN
        check("rst_sat", W'(sat_count), W'(0));
`endif

        write_bias(4'd3, pack4(16'h1000, 16'hF000, 16'h0000, 16'h7FFF));
        write_bias(4'd6, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        write_clip(15'h4000);
        for (int i = 0; i < 6; i++)
            send_and_check(vecs[i], i);
        tick();

        // Bias write lands on the same edge the beat is captured: old row applies.
        out_ready = 1'b1;
        bias_we = 1'b1; bias_waddr = 4'd5;
        bias_wdata = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        in_valid = 1'b1; in_data = '0; in_bias_idx = 4'd5; in_func = 2'b00;
        tick();
        bias_we = 1'b0;
        tick();
        in_valid = 1'b0;
        check("collide_old_valid", W'(out_valid), W'(1));
        check("collide_old_data", out_data, '0);
        tick();
        check("collide_new_valid", W'(out_valid), W'(1));
        check("collide_new_data", out_data, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        tick();

        // Backpressure: 8 beats with out_ready high one cycle in three.
        k = 0; c = 0;
        while (k < 8 && c < 60) begin
            out_ready = (c % 3 == 0);
            in_valid = 1'b1; in_bias_idx = 4'd0; in_func = 2'b00;
            in_data = pack4(16'(k*16 + 1), 16'(k*16 + 2), 16'(k*16 + 3), 16'(k*16 + 4));
            #1;
            acc = int'(in_ready);
            tick();
            if (acc != 0) k++;
            c++;
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0 && c < 100) begin
            out_ready = (c % 3 == 0);
            tick();
            c++;
        end
        check("bp_sent", W'(k), W'(8));
        check("bp_drained", W'(exp_q.size()), W'(0));

        // Randomized stream against the reference model.
        out_ready = 1'b1;
        write_clip(15'($urandom_range(0, 32767)));
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_data = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            in_bias_idx = 4'($urandom_range(0, 15));
            in_func = 2'($urandom);
            bias_we = ($urandom % 6) == 0;
            bias_waddr = 4'($urandom_range(0, 15));
            bias_wdata = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 1'b0; bias_we = 1'b0; out_ready = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            tick();
            c++;
        end
        check("rand_drained", W'(exp_q.size()), W'(0));
`ifdef ACT_SAT_COUNT_EN
        check("rand_sat", W'(sat_count), W'(m_sat));
`endif

        // Mid-stream reset with two beats held in the pipe.
        write_clip(15'h2000);
        out_ready = 1'b0;
        in_valid = 1'b1; in_bias_idx = 4'd3; in_func = 2'b00; in_data = '0;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", W'(out_valid), W'(1));
        check("pre_rst_full", W'(in_ready), W'(0));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("post_rst_valid", W'(out_valid), W'(0));
        check("post_rst_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_quiet", W'(out_valid), W'(0));
        end
`ifdef ACT_SAT_COUNT_EN
        sat_exp = 0;
        check("post_rst_sat", W'(sat_count), W'(0));
`endif
        begin
            vec_t v;
            v = '{pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 4'd3, 2'b00,
                  pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 0};
            send_and_check(v, 10);
            v = '{pack4(16'h7FFF, 16'h5000, 16'h0001, 16'h8001), 4'd0, 2'b11,
                  pack4(16'h7FFF, 16'h5000, 16'h0001, 16'h0000), 0};
            send_and_check(v, 11);
        end
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
